// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encodings and default operand width
package serial_sub_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle between a requester and the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = serial_sub_pkg::WIDTH_DEF);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;
  modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
endinterface

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit combinational subtractor cell x - y - bi
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one result bit per RUN cycle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  serial_subtractor_if.slave io
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic             bit_d, bit_bo;
  full_subtractor_bit u_cell (
    .x (a_q[0]),
    .y (b_q[0]),
    .bi(brw_q),
    .d (bit_d),
    .bo(bit_bo)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (state_q != RUN && io.start) begin
      state_d = RUN;
      a_d     = io.a;
      b_d     = io.b;
      brw_d   = io.bin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {bit_d, res_q[WIDTH-1:1]};
      brw_d = bit_bo;
      cnt_d = cnt_q + 1'b1;
      // on the last cycle the operand LSBs are the original MSBs, giving the overflow signs
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        diff_d  = res_d;
        bout_d  = bit_bo;
        zero_d  = (res_d == '0);
        ovf_d   = (a_q[0] ^ b_q[0]) & (bit_d ^ a_q[0]);
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end
  assign io.busy = (state_q == RUN);
  assign io.done = (state_q == DONE);
  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.zero = zero_q;
  assign io.ovf  = ovf_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; accepted only when busy=0.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled on the accepted start cycle.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled on the accepted start cycle.
REQ-007 SHALL have port bin  input  1  borrow-in for chaining; sampled on the accepted start cycle.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a result becomes valid.
REQ-010 SHALL have port diff  output  WIDTH  result a-b-bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  final borrow-out, meaning unsigned a < b+bin.
REQ-012 SHALL have port zero  output  1  high when diff==0.
REQ-013 SHALL have port ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 SHALL load a and b into shift registers, bin into the borrow flop and bit counter=0, then go to RUN.
REQ-016 RUN: each cycle SHALL compute one result bit, LSB first, from operand LSBs and the borrow flop, shift it into the result register, register the new borrow, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; after the cycle with counter=WIDTH-1 the FSM SHALL go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; diff, bout, zero and ovf SHALL be valid from this cycle onward; the next state SHALL be IDLE.
REQ-019 Latency: start accepted on edge N; done=1 in the cycle after edge N+WIDTH; the next start is accepted from the DONE cycle.
REQ-020 busy SHALL be 1 in RUN only; start SHALL also be accepted in DONE (back-to-back), going directly to RUN.
REQ-021 start while busy=1 SHALL be ignored, with no effect on operands, counter or outputs.
REQ-022 diff, bout, zero and ovf SHALL hold their last values until the next done; they are not updated mid-RUN. The internal shift register is separate from the diff output register.
REQ-023 ovf SHALL be (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the latched operands.
REQ-024 The counter SHALL be $clog2(WIDTH)+1 bits wide; no wrap is permitted within RUN.

Reset
REQ-025 rst=1 SHALL force state to IDLE and clear busy, done, diff, bout, zero, ovf, the shift registers, the borrow flop and the counter, with zero taking reset value 0.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse.

Structure
REQ-028 Shared package serial_sub_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default.
REQ-029 The per-bit cell SHALL be a sub-module full_subtractor_bit (combinational):
- d = x^y^bi
- bo = (~x&y) | (~(x^y)&bi)
REQ-030 The block SHALL instantiate it once.

Verification
REQ-031 Basic subtraction: WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, zero=0, ovf=0, done 9 cycles after start.
REQ-032 Borrow and zero flags:
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
- a=0x55, b=0x55 -> diff=0x00, zero=1.
REQ-033 Overflow and borrow-in:
- a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 Ignored start: start pulsed again at RUN cycle 3 with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-035 Reset mid-operation and back-to-back: rst at RUN cycle 4 -> no done, all outputs 0 next cycle; then start held high through DONE -> second operation begins with no idle cycle.
